// File: rtl/accbuf_multi_if.sv
// Bus bundle for accbuf_multi: arm/trigger controls, per-channel results,
// readback port and per-channel status.
interface accbuf_multi_if #(
    parameter int NCHAN = 4,
    parameter int DW    = 32,
    parameter int AW    = 12,
    parameter int CW    = 2
);
    logic                      start;
    logic                      trig;
    logic                      wrap_mode;
    logic [NCHAN-1:0]          done;
    logic [NCHAN*DW-1:0]       xacc;
    logic [NCHAN*DW-1:0]       yacc;
    logic [CW-1:0]             rd_chan;
    logic [AW-1:0]             rd_addr;
    logic [DW-1:0]             rd_data;
    logic [NCHAN-1:0]          full;
    logic [NCHAN-1:0]          wrapped;
    logic [NCHAN-1:0]          collision;
    logic [NCHAN*(AW+1)-1:0]   wptr;
    logic [NCHAN*32-1:0]       count;

    modport master (
        output start, trig, wrap_mode, done, xacc, yacc, rd_chan, rd_addr,
        input  rd_data, full, wrapped, collision, wptr, count
    );

    modport slave (
        input  start, trig, wrap_mode, done, xacc, yacc, rd_chan, rd_addr,
        output rd_data, full, wrapped, collision, wptr, count
    );
endinterface

// File: rtl/accbuf_multi.sv
// Multi-channel (x, y) accumulation result buffer with stop/circular modes.
// Optional pair counters built when ACCBUF_COUNT_EN is defined.
module accbuf_multi #(
    parameter int NCHAN = 4,
    parameter int DW    = 32,
    parameter int AW    = 12,
    parameter int CW    = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    accbuf_multi_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WR_X, WR_Y} state_t;

    logic                   armed_pending;
    logic                   arm;
    logic [NCHAN-1:0][DW-1:0] ram_q;
    logic [CW-1:0]          chan_q;
    logic [DW-1:0]          rd_sel;
    logic [DW-1:0]          rd_q;

    // A start in the trig cycle itself arms immediately.
    assign arm = bus.trig & (armed_pending | bus.start);

    always_ff @(posedge clk) begin
        if (!reset_n)       armed_pending <= 1'b0;
        else if (arm)       armed_pending <= 1'b0;
        else if (bus.start) armed_pending <= 1'b1;
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_ch
        state_t         state;
        logic [AW:0]    wptr;
        logic [AW:0]    wptr_nxt;
        logic           wrapped;
        logic           collision;
        logic           mode;
        logic           wrap_hit;
        logic           we;
        logic [DW-1:0]  xh;
        logic [DW-1:0]  yh;
        logic [DW-1:0]  wdata;
        logic [DW-1:0]  rq;
        logic [DW-1:0]  mem [2**AW];

        // Circular mode keeps the MSB clear so full never asserts.
        assign wrap_hit = mode && (wptr[AW-1:0] == '1);
        assign wptr_nxt = mode ? {1'b0, wptr[AW-1:0] + AW'(1)} : wptr + (AW+1)'(1);
        assign we       = reset_n && !arm && (state != IDLE);
        assign wdata    = (state == WR_X) ? xh : yh;

        always_ff @(posedge clk) begin
            if (we) mem[wptr[AW-1:0]] <= wdata;
            rq <= mem[bus.rd_addr];
        end
        assign ram_q[c] = rq;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state     <= IDLE;
                wptr      <= {1'b1, {AW{1'b0}}};
                wrapped   <= 1'b0;
                collision <= 1'b0;
                mode      <= 1'b0;
                xh        <= '0;
                yh        <= '0;
            end else if (arm) begin
                state     <= IDLE;
                wptr      <= '0;
                wrapped   <= 1'b0;
                collision <= 1'b0;
                mode      <= bus.wrap_mode;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.done[c] && !wptr[AW]) begin
                            xh    <= bus.xacc[c*DW +: DW];
                            yh    <= bus.yacc[c*DW +: DW];
                            state <= WR_X;
                        end
                    end
                    WR_X: begin
                        wptr      <= wptr_nxt;
                        wrapped   <= wrapped | wrap_hit;
                        collision <= collision | bus.done[c];
                        state     <= WR_Y;
                    end
                    WR_Y: begin
                        wptr      <= wptr_nxt;
                        wrapped   <= wrapped | wrap_hit;
                        collision <= collision | bus.done[c];
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

`ifdef ACCBUF_COUNT_EN
        logic [31:0] cnt;
        always_ff @(posedge clk) begin
            if (!reset_n || arm)
                cnt <= '0;
            else if (state == WR_Y && cnt != '1)
                cnt <= cnt + 32'd1;
        end
        assign bus.count[c*32 +: 32] = cnt;
`else
        assign bus.count[c*32 +: 32] = '0;
`endif

        assign bus.full[c]                  = wptr[AW];
        assign bus.wrapped[c]               = wrapped;
        assign bus.collision[c]             = collision;
        assign bus.wptr[c*(AW+1) +: (AW+1)] = wptr;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) chan_q <= '0;
        else          chan_q <= bus.rd_chan;
    end

    // Unmatched channel selects fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < NCHAN; i++)
            if (chan_q == CW'(i)) rd_sel = ram_q[i];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) rd_q <= '0;
        else          rd_q <= rd_sel;
    end

    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_accbuf_multi.sv
// Directed bench for accbuf_multi (AW=4, CW=3) with a transaction-level
// reference model compared against the DUT on every cycle.
module tb_accbuf_multi;
    localparam int NCHAN = 4;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int CW    = 3;
    localparam int DEPTH = 1 << AW;
`ifdef ACCBUF_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    accbuf_multi_if #(.NCHAN(NCHAN), .DW(DW), .AW(AW), .CW(CW)) bus ();

    accbuf_multi #(.NCHAN(NCHAN), .DW(DW), .AW(AW), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: an accepted result lands as x one edge later and y two edges later.
    longint      cyc = 0;
    bit          m_pend;
    int unsigned m_wptr [NCHAN];
    bit          m_mode [NCHAN];
    bit          m_wr   [NCHAN];
    bit          m_col  [NCHAN];
    bit          m_busy [NCHAN];
    longint      m_acc  [NCHAN];
    logic [31:0] m_px   [NCHAN];
    logic [31:0] m_py   [NCHAN];
    int unsigned m_cnt  [NCHAN];
    logic [31:0] m_mem  [NCHAN][DEPTH];
    bit          m_known[NCHAN][DEPTH];
    logic [31:0] m_s1, m_rd;
    bit          m_s1k, m_rdk;

    task automatic m_store(input int c, input logic [31:0] d);
        m_mem[c][m_wptr[c] % DEPTH]   = d;
        m_known[c][m_wptr[c] % DEPTH] = 1'b1;
        if (m_mode[c]) begin
            if (m_wptr[c] == DEPTH - 1) begin
                m_wptr[c] = 0;
                m_wr[c]   = 1'b1;
            end else begin
                m_wptr[c]++;
            end
        end else begin
            m_wptr[c]++;
        end
    endtask

    always @(posedge clk) begin
        bit arm;
        cyc++;
        arm = bus.trig && (m_pend || bus.start);
        if (!reset_n) begin
            m_rd = '0; m_rdk = 1'b1; m_s1k = 1'b0;
        end else begin
            m_rd = m_s1; m_rdk = m_s1k;
            if (bus.rd_chan < NCHAN) begin
                m_s1  = m_mem[bus.rd_chan][bus.rd_addr];
                m_s1k = m_known[bus.rd_chan][bus.rd_addr];
            end else begin
                m_s1 = '0; m_s1k = 1'b1;
            end
        end
        for (int c = 0; c < NCHAN; c++) begin
            if (!reset_n) begin
                m_wptr[c] = DEPTH; m_mode[c] = 0; m_wr[c] = 0; m_col[c] = 0;
                m_busy[c] = 0; m_cnt[c] = 0;
            end else if (arm) begin
                m_wptr[c] = 0; m_mode[c] = bus.wrap_mode; m_wr[c] = 0; m_col[c] = 0;
                m_busy[c] = 0; m_cnt[c] = 0;
            end else begin
                bit was_busy;
                was_busy = m_busy[c];
                if (m_busy[c] && cyc == m_acc[c] + 1) begin
                    m_store(c, m_px[c]);
                end else if (m_busy[c] && cyc == m_acc[c] + 2) begin
                    m_store(c, m_py[c]);
                    if (m_cnt[c] != 32'hFFFF_FFFF) m_cnt[c]++;
                    m_busy[c] = 0;
                end
                if (bus.done[c]) begin
                    if (was_busy) m_col[c] = 1'b1;
                    else if (!(!m_mode[c] && m_wptr[c] == DEPTH)) begin
                        m_busy[c] = 1'b1;
                        m_acc[c]  = cyc;
                        m_px[c]   = bus.xacc[c*32 +: 32];
                        m_py[c]   = bus.yacc[c*32 +: 32];
                    end
                end
            end
        end
        if (!reset_n || arm) m_pend = 1'b0;
        else if (bus.start)  m_pend = 1'b1;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int c = 0; c < NCHAN; c++) begin
                chk($sformatf("full[%0d]", c), bus.full[c],
                    (!m_mode[c] && m_wptr[c] == DEPTH) ? 1 : 0);
                chk($sformatf("wrapped[%0d]", c), bus.wrapped[c], m_wr[c]);
                chk($sformatf("collision[%0d]", c), bus.collision[c], m_col[c]);
                chk($sformatf("wptr[%0d]", c), bus.wptr[c*(AW+1) +: (AW+1)], m_wptr[c]);
                chk($sformatf("count[%0d]", c), bus.count[c*32 +: 32], CNT_EN ? m_cnt[c] : 0);
            end
            if (m_rdk) chk("rd_data", bus.rd_data, m_rd);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int c, input logic [31:0] x, input logic [31:0] y);
        bus.done[c]            = 1'b1;
        bus.xacc[c*32 +: 32]   = x;
        bus.yacc[c*32 +: 32]   = y;
        tick();
        bus.done = '0;
    endtask

    task automatic rd(input int c, input int a, input logic [31:0] exp, input string name);
        bus.rd_chan = CW'(c);
        bus.rd_addr = AW'(a);
        tick(2);
        chk(name, bus.rd_data, exp);
    endtask

    task automatic arm_seq(input bit wm);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.trig = 1'b1; bus.wrap_mode = wm; tick(); bus.trig = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.start = 0; bus.trig = 0; bus.wrap_mode = 0; bus.done = '0;
        bus.xacc = '0; bus.yacc = '0; bus.rd_chan = '0; bus.rd_addr = '0;
        tick(3);
        chk("reset_rd_data", bus.rd_data, 0);
        chk("reset_full", bus.full, 4'hF);
        chk("reset_wptr0", bus.wptr[4:0], 5'h10);
        chk("reset_collision", bus.collision, 0);
        reset_n = 1'b1;

        // Unarmed: done ignored.
        pulse(0, 32'hDEAD, 32'hBEEF); tick(3);
        chk("unarmed_full", bus.full, 4'hF);
        chk("unarmed_wptr0", bus.wptr[4:0], 5'h10);

        // Basic pair write on channel 1.
        arm_seq(1'b0);
        pulse(1, 32'h11, 32'h22); tick(3);
        chk("ch1_wptr", bus.wptr[9:5], 2);
        chk("model_wptr1", m_wptr[1], 2);
        chk("ch1_count", bus.count[63:32], CNT_EN ? 1 : 0);
        rd(1, 1, 32'h22, "rd_ch1_y");
        rd(1, 0, 32'h11, "rd_ch1_x");

        // Stop mode fill on channel 2.
        for (int k = 0; k < 9; k++) begin
            pulse(2, 32'h200 + k, 32'h300 + k); tick(3);
            if (k == 7) begin
                chk("stop_full_after8", bus.full[2], 1);
                chk("stop_wptr_after8", bus.wptr[14:10], 5'h10);
            end
        end
        chk("stop_full_after9", bus.full[2], 1);
        chk("stop_collision", bus.collision[2], 0);
        rd(2, 15, 32'h307, "rd_ch2_last_y");

        // Circular mode on channel 0.
        arm_seq(1'b1);
        bus.wrap_mode = 1'b0;
        for (int k = 0; k < 9; k++) begin
            pulse(0, 32'hA00 + k, 32'hB00 + k); tick(3);
        end
        chk("wrap_full0", bus.full[0], 0);
        chk("wrap_wrapped0", bus.wrapped[0], 1);
        chk("wrap_wptr0", bus.wptr[4:0], 2);
        chk("model_wrapped0", m_wr[0], 1);
        rd(0, 0, 32'hA08, "rd_wrap_x9");
        rd(0, 1, 32'hB08, "rd_wrap_y9");

        // Back-to-back done on channel 3.
        bus.done[3] = 1'b1; bus.xacc[127:96] = 32'h33; bus.yacc[127:96] = 32'h44; tick();
        bus.xacc[127:96] = 32'h55; bus.yacc[127:96] = 32'h66; tick();
        bus.done = '0; tick(3);
        chk("b2b_collision3", bus.collision[3], 1);
        chk("b2b_wptr3", bus.wptr[19:15], 2);
        chk("b2b_count3", bus.count[127:96], CNT_EN ? 1 : 0);
        rd(3, 0, 32'h33, "rd_b2b_x");
        rd(3, 1, 32'h44, "rd_b2b_y");

        // Re-arm while channel 0 sits in WR_X.
        pulse(0, 32'h77, 32'h88);
        bus.start = 1'b1; bus.trig = 1'b1; tick();
        bus.start = 1'b0; bus.trig = 1'b0; tick(3);
        chk("abort_wptr0", bus.wptr[4:0], 0);
        chk("abort_collision3", bus.collision[3], 0);
        rd(0, 3, 32'hB01, "rd_abort_y_kept");

        // Done coincident with an arming trig is discarded.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.trig = 1'b1; bus.done[1] = 1'b1; tick();
        bus.trig = 1'b0; bus.done = '0; tick(3);
        chk("armdone_wptr1", bus.wptr[9:5], 0);
        chk("armdone_col1", bus.collision[1], 0);

        // Trig with no pending start has no effect.
        pulse(1, 32'h99, 32'hAA); tick(3);
        bus.trig = 1'b1; tick(); bus.trig = 1'b0; tick();
        chk("lonetrig_wptr1", bus.wptr[9:5], 2);
        rd(1, 1, 32'hAA, "rd_lonetrig_y");

        rd(6, 1, 32'h0, "rd_bad_chan");
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
